// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out framed transmitter.
//
// Accepts one WIDTH-bit word through a valid/ready handshake and sends it on
// a single line as a frame: start bit (0), data LSB first, optional even
// parity, stop bit (1). Each bit is held on the line for DIV clock cycles.
// ready_out is high in IDLE and in the last cycle of STOP, so back-to-back
// words go out with no idle gap between frames.
//
// Optional feature: define SERIAL_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
//
// Parameters:
//   WIDTH     data bits per frame (1..32)
//   DIV       clock cycles per serial bit (1..256)
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high reset
//   data_in    word to transmit, sampled on the accept edge only
//   valid_in   data_in holds a word to send
//   ready_out  block can accept a word this cycle
//   s          serial line, idles high
//   frame      high while start/data/parity/stop bits are on s
//   busy       high from the accept edge until frame end

module serial_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             s,
  output logic             frame,
  output logic             busy
);

  localparam int unsigned BitW = $clog2(WIDTH + 1);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]  bit_q,   bit_d;
  logic [DivW-1:0]  div_q,   div_d;
  logic             s_q,     s_d;
  logic             frame_q, frame_d;
  logic             busy_q,  busy_d;
  logic             ready_q, ready_d;

`ifdef SERIAL_TX_PARITY_EN
  logic             par_q,   par_d;
`endif

  logic accept;
  logic bit_end;

  assign accept  = valid_in & ready_q;
  assign bit_end = (div_q == DivLast);

  // Next-state: state, shift register, bit and divider counters.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      StIdle: begin
        div_d = '0;
        if (accept) begin
          state_d = StStart;
          shreg_d = data_in;
          bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ^data_in;
`endif
        end
      end

      StStart: begin
        if (bit_end) begin
          div_d   = '0;
          state_d = StData;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StData: begin
        if (bit_end) begin
          div_d   = '0;
          // Bit 0 of the shift register is always the bit on the line.
          shreg_d = shreg_q >> 1;
          if (bit_q == BitLast) begin
            bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          div_d   = '0;
          state_d = StStop;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif

      StStop: begin
        if (bit_end) begin
          div_d = '0;
          // ready_q is high in this cycle, so a waiting word starts at once.
          if (accept) begin
            state_d = StStart;
            shreg_d = data_in;
            bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
            par_d   = ^data_in;
`endif
          end else begin
            state_d = StIdle;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        shreg_d = '0;
        bit_d   = '0;
        div_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered and
  // change only on clock edges.
  always_comb begin
    s_d     = 1'b1;
    frame_d = (state_d != StIdle);
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle) || ((state_d == StStop) && (div_d == DivLast));

    case (state_d)
      StStart:  s_d = 1'b0;
      StData:   s_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
      StParity: s_d = par_d;
`endif
      default:  s_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      s_q     <= 1'b1;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      s_q     <= s_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign s         = s_q;
  assign frame     = frame_q;
  assign busy      = busy_q;
  assign ready_out = ready_q;

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx: two instances (DIV=1 and DIV=4, WIDTH=8) driven
// with directed words; expected line levels come from frame_bits().

module tb_serial_tx;

  localparam int unsigned W = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FL = W + 3;
`else
  localparam int FL = W + 2;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d1, d4;
  logic       v1, v4;
  logic       r1, s1, f1, b1;
  logic       r4, s4, f4, b4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(8), .DIV(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .data_in   (d1),
    .valid_in  (v1),
    .ready_out (r1),
    .s         (s1),
    .frame     (f1),
    .busy      (b1)
  );

  serial_tx #(.WIDTH(8), .DIV(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .data_in   (d4),
    .valid_in  (v4),
    .ready_out (r4),
    .s         (s4),
    .frame     (f4),
    .busy      (b4)
  );

  // Line level for each bit slot of a frame: start, LSB-first data,
  // optional even parity, stop.
  function automatic logic [15:0] frame_bits(input logic [7:0] d);
    logic [15:0] fb;
    fb      = '1;
    fb[0]   = 1'b0;
    fb[8:1] = d;
`ifdef SERIAL_TX_PARITY_EN
    fb[9]   = ^d;
`endif
    return fb;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    v1 = 1'b0; v4 = 1'b0; d1 = 8'h00; d4 = 8'h00;
    tick;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      n_tests++;
      if ({s1, f1, b1, r1} !== 4'b1001) begin
        n_fail++;
        $display("FAIL reset_idle_div1 cycle %0d: s/frame/busy/ready=%b want 1001", i,
                 {s1, f1, b1, r1});
      end
      n_tests++;
      if ({s4, f4, b4, r4} !== 4'b1001) begin
        n_fail++;
        $display("FAIL reset_idle_div4 cycle %0d: s/frame/busy/ready=%b want 1001", i,
                 {s4, f4, b4, r4});
      end
    end
  endtask

  task automatic test_single_frame;
    logic [15:0] fb;
    fb = frame_bits(8'hA5);
    d1 = 8'hA5;
    v1 = 1'b1;
    tick;
    v1 = 1'b0;
    d1 = 8'h00;
    for (int i = 0; i < FL; i++) begin
      if (i != 0) tick;
      n_tests++;
      if ({s1, f1, b1, r1} !== {fb[i], 1'b1, 1'b1, logic'(i == FL - 1)}) begin
        n_fail++;
        $display("FAIL single_frame slot %0d: s/frame/busy/ready=%b want %b", i,
                 {s1, f1, b1, r1}, {fb[i], 1'b1, 1'b1, logic'(i == FL - 1)});
      end
    end
    tick;
    n_tests++;
    if ({s1, f1, b1, r1} !== 4'b1001) begin
      n_fail++;
      $display("FAIL single_frame_end: s/frame/busy/ready=%b want 1001", {s1, f1, b1, r1});
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] fa, fb;
    logic        exp_s;
    fa = frame_bits(8'h01);
    fb = frame_bits(8'hFF);
    d1 = 8'h01;
    v1 = 1'b1;
    tick;
    d1 = 8'hFF;
    for (int i = 0; i < 2 * FL; i++) begin
      if (i != 0) tick;
      if (i == FL) v1 = 1'b0;
      exp_s = (i < FL) ? fa[i] : fb[i - FL];
      n_tests++;
      if ({s1, f1, b1, r1} !== {exp_s, 1'b1, 1'b1, logic'(i == FL - 1 || i == 2 * FL - 1)}) begin
        n_fail++;
        $display("FAIL back_to_back slot %0d: s/frame/busy/ready=%b want %b", i,
                 {s1, f1, b1, r1}, {exp_s, 1'b1, 1'b1, logic'(i == FL - 1 || i == 2 * FL - 1)});
      end
    end
    tick;
    n_tests++;
    if ({s1, f1, b1, r1} !== 4'b1001) begin
      n_fail++;
      $display("FAIL back_to_back_end: s/frame/busy/ready=%b want 1001", {s1, f1, b1, r1});
    end
  endtask

  task automatic test_divider;
    logic [15:0] fb;
    fb = frame_bits(8'h3C);
    d4 = 8'h3C;
    v4 = 1'b1;
    tick;
    v4 = 1'b0;
    for (int i = 0; i < 4 * FL; i++) begin
      if (i != 0) tick;
      // Word offered while the block is busy must be dropped.
      if (i == 15) begin d4 = 8'h00; v4 = 1'b1; end
      if (i == 16) v4 = 1'b0;
      n_tests++;
      if ({s4, f4, b4, r4} !== {fb[i / 4], 1'b1, 1'b1, logic'(i == 4 * FL - 1)}) begin
        n_fail++;
        $display("FAIL divider slot %0d: s/frame/busy/ready=%b want %b", i,
                 {s4, f4, b4, r4}, {fb[i / 4], 1'b1, 1'b1, logic'(i == 4 * FL - 1)});
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick;
      n_tests++;
      if ({s4, f4, b4, r4} !== 4'b1001) begin
        n_fail++;
        $display("FAIL divider_ignored_word cycle %0d: s/frame/busy/ready=%b want 1001", i,
                 {s4, f4, b4, r4});
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] fb;
    d1 = 8'hA5;
    v1 = 1'b1;
    tick;
    v1 = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    // Now in DATA bit 3 of 0xA5, which is 0.
    n_tests++;
    if ({s1, f1, b1, r1} !== 4'b0110) begin
      n_fail++;
      $display("FAIL mid_frame_bit3: s/frame/busy/ready=%b want 0110", {s1, f1, b1, r1});
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_tests++;
    if ({s1, f1, b1, r1} !== 4'b1001) begin
      n_fail++;
      $display("FAIL mid_frame_reset: s/frame/busy/ready=%b want 1001", {s1, f1, b1, r1});
    end
    tick;
    n_tests++;
    if ({s1, f1, b1, r1} !== 4'b1001) begin
      n_fail++;
      $display("FAIL mid_frame_no_resume: s/frame/busy/ready=%b want 1001", {s1, f1, b1, r1});
    end
    fb = frame_bits(8'h5A);
    d1 = 8'h5A;
    v1 = 1'b1;
    tick;
    v1 = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i != 0) tick;
      n_tests++;
      if ({s1, f1, b1, r1} !== {fb[i], 1'b1, 1'b1, logic'(i == FL - 1)}) begin
        n_fail++;
        $display("FAIL after_reset_frame slot %0d: s/frame/busy/ready=%b want %b", i,
                 {s1, f1, b1, r1}, {fb[i], 1'b1, 1'b1, logic'(i == FL - 1)});
      end
    end
    tick;
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] words [2];
    logic       par   [2];
    logic [15:0] fb;
    words[0] = 8'hA5; par[0] = 1'b0;
    words[1] = 8'h07; par[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      fb = frame_bits(words[k]);
      d1 = words[k];
      v1 = 1'b1;
      tick;
      v1 = 1'b0;
      for (int i = 0; i < 11; i++) begin
        if (i != 0) tick;
        n_tests++;
        if ({s1, f1, r1} !== {fb[i], 1'b1, logic'(i == 10)}) begin
          n_fail++;
          $display("FAIL parity_frame %0d slot %0d: s/frame/ready=%b want %b", k, i,
                   {s1, f1, r1}, {fb[i], 1'b1, logic'(i == 10)});
        end
        if (i == 9) begin
          n_tests++;
          if (s1 !== par[k]) begin
            n_fail++;
            $display("FAIL parity_bit %0d: s=%b want %b", k, s1, par[k]);
          end
        end
      end
      tick;
      n_tests++;
      if ({s1, f1, b1, r1} !== 4'b1001) begin
        n_fail++;
        $display("FAIL parity_end %0d: s/frame/busy/ready=%b want 1001", k, {s1, f1, b1, r1});
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_divider;
    test_reset_mid_frame;
`ifdef SERIAL_TX_PARITY_EN
    test_parity;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
